// File: rtl/integrador_trapezoidal_pkg.sv
// Shared fixed-point constants and clamp helper for the integral branch.
// Provides default Q-format widths, default accumulator limits and a wide
// signed clamp used by the saturator (and later by the PID output stage).
package integrador_trapezoidal_pkg;

    localparam int unsigned MAGNITUD_DEF = 17;
    localparam int unsigned DECIMAL_DEF  = 0;
    localparam int unsigned N_DEF        = MAGNITUD_DEF + DECIMAL_DEF + 1;

    // Widest intermediate the clamp helper accepts; callers sign-extend into it.
    localparam int unsigned WIDE_W = 64;

    localparam longint LIM_SUP_DEF = (longint'(1) <<< (N_DEF - 1)) - 1;
    localparam longint LIM_INF_DEF = -(longint'(1) <<< (N_DEF - 1));

    // Clamp a signed wide value into [lim_inf, lim_sup].
    function automatic logic signed [WIDE_W-1:0] clamp(
        input logic signed [WIDE_W-1:0] value,
        input logic signed [WIDE_W-1:0] lim_inf,
        input logic signed [WIDE_W-1:0] lim_sup
    );
        logic signed [WIDE_W-1:0] r;
        r = value;
        if (value > lim_sup) begin
            r = lim_sup;
        end else if (value < lim_inf) begin
            r = lim_inf;
        end
        return r;
    endfunction

endpackage

// File: rtl/integrador_trapezoidal_if.sv
// Sample/result bundle of the trapezoidal integrator.
// enable/clear/y flow from the controller (master) into the integrator (slave);
// integrador/valido/saturado flow back.
interface integrador_trapezoidal_if
    import integrador_trapezoidal_pkg::*;
#(
    parameter int unsigned N = N_DEF
);

    logic                enable;
    logic                clear;
    logic signed [N-1:0] y;
    logic signed [N-1:0] integrador;
    logic                valido;
    logic                saturado;

    modport master (
        output enable, clear, y,
        input  integrador, valido, saturado
    );

    modport slave (
        input  enable, clear, y,
        output integrador, valido, saturado
    );

endinterface

// File: rtl/integrador_trapezoidal_saturador.sv
// Combinational clamp of a wide signed value into an N-bit signed range,
// plus a flag telling whether the clamped result sits on either limit.
// Ports: value (W_IN signed in), clamped_c (N signed out), at_limit_c (out).
// W_IN must not exceed the package WIDE_W.
module integrador_trapezoidal_saturador
    import integrador_trapezoidal_pkg::*;
#(
    parameter int unsigned W_IN    = 2 * N_DEF + 2,
    parameter int unsigned N       = N_DEF,
    parameter longint      LIM_SUP = LIM_SUP_DEF,
    parameter longint      LIM_INF = LIM_INF_DEF
) (
    input  logic signed [W_IN-1:0] value,
    output logic signed [N-1:0]    clamped_c,
    output logic                   at_limit_c
);

    logic signed [WIDE_W-1:0] wide;
    logic signed [WIDE_W-1:0] lim_w;

    // Sign-extend, clamp at full width, then narrow (always in range after clamp).
    always_comb begin
        wide       = WIDE_W'(value);
        lim_w      = clamp(wide, WIDE_W'(LIM_INF), WIDE_W'(LIM_SUP));
        clamped_c  = N'(lim_w);
        at_limit_c = (lim_w == WIDE_W'(LIM_SUP)) || (lim_w == WIDE_W'(LIM_INF));
    end

endmodule

// File: rtl/integrador_trapezoidal.sv
// Trapezoidal discrete integrator for the servo integral branch.
// Each strobe adds GANANCIA*(y[n]+y[n-1])/2 (with optional extra coarse shift)
// into an accumulator clamped to [LIM_INF, LIM_SUP] with anti-windup.
// Ports: clk, reset (async, active-high), bus (slave): enable, clear, y in;
//        integrador, valido, saturado out (registered).
// Pipeline: stage 1 registers the scaled increment, stage 2 accumulates.
module integrador_trapezoidal
    import integrador_trapezoidal_pkg::*;
#(
    parameter int unsigned Magnitud = MAGNITUD_DEF,
    parameter int unsigned Decimal  = DECIMAL_DEF,
    parameter int unsigned N        = Magnitud + Decimal + 1,
    parameter longint      GANANCIA = 1,
    parameter int unsigned DESPLAZA = 0,
    parameter longint      LIM_SUP  = (longint'(1) <<< (N - 1)) - 1,
    parameter longint      LIM_INF  = -(longint'(1) <<< (N - 1))
) (
    input logic                   clk,
    input logic                   reset,
    integrador_trapezoidal_if.slave bus
);

    localparam int unsigned W_S = N + 1;
    localparam int unsigned W_P = 2 * N + 1;
    localparam int unsigned W_T = 2 * N + 2;
    // The extra +1 turns the shift into the trapezoid's /2.
    localparam int unsigned SH  = Decimal + 1 + DESPLAZA;

    localparam logic signed [N-1:0]   GAIN_N = N'(GANANCIA);
    localparam logic signed [W_P-1:0] GAIN_P = W_P'(GAIN_N);

    logic signed [N-1:0]   x_prev;
    logic signed [N-1:0]   acc;
    logic signed [W_P-1:0] inc;
    logic                  v1;
    logic                  valido;
    logic                  saturado;

    logic signed [W_S-1:0] s_c;
    logic signed [W_P-1:0] p_c;
    logic signed [W_P-1:0] inc_c;
    logic signed [W_T-1:0] t_c;
    logic signed [N-1:0]   clamped_c;
    logic                  at_limit_c;

    // Stage-1 increment and stage-2 sum; widths chosen so nothing overflows.
    always_comb begin
        s_c   = W_S'(bus.y) + W_S'(x_prev);
        p_c   = W_P'(s_c) * GAIN_P;
        inc_c = p_c >>> SH;
        t_c   = W_T'(acc) + W_T'(inc);
    end

    integrador_trapezoidal_saturador #(
        .W_IN    (W_T),
        .N       (N),
        .LIM_SUP (LIM_SUP),
        .LIM_INF (LIM_INF)
    ) u_saturador (
        .value      (t_c),
        .clamped_c  (clamped_c),
        .at_limit_c (at_limit_c)
    );

    // Pipeline registers; clear beats enable and drops any pending increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_prev   <= '0;
            inc      <= '0;
            v1       <= 1'b0;
            acc      <= '0;
            valido   <= 1'b0;
            saturado <= 1'b0;
        end else if (bus.clear) begin
            x_prev   <= '0;
            inc      <= '0;
            v1       <= 1'b0;
            acc      <= '0;
            valido   <= 1'b0;
            saturado <= 1'b0;
        end else begin
            valido <= v1;
            if (v1) begin
                acc      <= clamped_c;
                saturado <= at_limit_c;
            end
            if (bus.enable) begin
                inc    <= inc_c;
                x_prev <= bus.y;
                v1     <= 1'b1;
            end else begin
                v1 <= 1'b0;
            end
        end
    end

    // The clamped accumulator is the published result.
    assign bus.integrador = acc;
    assign bus.valido     = valido;
    assign bus.saturado   = saturado;

endmodule
